// File: rtl/mmio_gpio_ctrl.sv
// Memory-mapped GPIO controller: synchronised and debounced inputs, register-driven
// outputs, per-bit edge capture with a level interrupt, single-cycle bus decode.
module mmio_gpio_ctrl #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_valid,
  input  logic             bus_we,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_rvalid,
  output logic             bus_err,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic             irq
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);

  localparam logic [2:0] OFF_IN   = 3'd0;
  localparam logic [2:0] OFF_OUT  = 3'd1;
  localparam logic [2:0] OFF_SET  = 3'd2;
  localparam logic [2:0] OFF_CLR  = 3'd3;
  localparam logic [2:0] OFF_STAT = 3'd4;
  localparam logic [2:0] OFF_IEN  = 3'd5;
  localparam logic [2:0] OFF_POL  = 3'd6;
  localparam logic [2:0] OFF_NONE = 3'd7;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0] in_q, in_d, synced;
  logic [WIDTH-1:0] out_q, out_d, stat_q, stat_d, ien_q, ien_d, pol_q, pol_d;
  logic [WIDTH-1:0] wmask, evt;
  logic [31:0]      rd_mux;
  logic [2:0]       off;
  logic             hit, wr, rd;
  logic             unused_bits;

  // Address bits below word granularity and wdata bits above WIDTH carry no meaning.
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

  assign hit    = bus_valid && (bus_addr[31:5] == BASE_ADDR[31:5]);
  assign off    = bus_addr[4:2];
  assign wr     = hit && bus_we;
  assign rd     = hit && !bus_we;
  assign wmask  = bus_wdata[WIDTH-1:0];
  assign synced = sync_q[SYNC_STAGES-1];

  // Debounce: a differing synced bit must persist DEBOUNCE cycles before IN follows.
  always_comb begin
    in_d  = in_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (synced[i] == in_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        in_d[i]  = synced[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign evt = ((in_d & ~in_q) & ~pol_q) | ((~in_d & in_q) & pol_q);

  // Register writes; a new edge event overrides a same-cycle W1C on that bit.
  always_comb begin
    out_d  = out_q;
    ien_d  = ien_q;
    pol_d  = pol_q;
    stat_d = stat_q;
    if (wr) begin
      case (off)
        OFF_OUT:  out_d  = wmask;
        OFF_SET:  out_d  = out_q | wmask;
        OFF_CLR:  out_d  = out_q & ~wmask;
        OFF_STAT: stat_d = stat_q & ~wmask;
        OFF_IEN:  ien_d  = wmask;
        OFF_POL:  pol_d  = wmask;
        default:  ;
      endcase
    end
    stat_d = stat_d | evt;
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_IN:   rd_mux = 32'(in_q);
      OFF_OUT:  rd_mux = 32'(out_q);
      OFF_STAT: rd_mux = 32'(stat_q);
      OFF_IEN:  rd_mux = 32'(ien_q);
      OFF_POL:  rd_mux = 32'(pol_q);
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      in_q       <= '0;
      out_q      <= '0;
      stat_q     <= '0;
      ien_q      <= '0;
      pol_q      <= '0;
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
      bus_err    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      cnt_q      <= cnt_d;
      in_q       <= in_d;
      out_q      <= out_d;
      stat_q     <= stat_d;
      ien_q      <= ien_d;
      pol_q      <= pol_d;
      bus_rvalid <= rd;
      bus_err    <= hit && (off == OFF_NONE);
      irq        <= |(stat_q & ien_q);
      if (rd) bus_rdata <= rd_mux;
    end
  end

  assign gpio_out = out_q;

endmodule

// File: tb/tb_mmio_gpio_ctrl.sv
// Directed bench for mmio_gpio_ctrl; read data checked through an expected-value queue.
module tb_mmio_gpio_ctrl;

  localparam logic [31:0] A_IN   = 32'h400;
  localparam logic [31:0] A_OUT  = 32'h404;
  localparam logic [31:0] A_SET  = 32'h408;
  localparam logic [31:0] A_CLR  = 32'h40C;
  localparam logic [31:0] A_STAT = 32'h410;
  localparam logic [31:0] A_IEN  = 32'h414;
  localparam logic [31:0] A_POL  = 32'h418;
  localparam logic [31:0] A_NONE = 32'h41C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_rvalid, bus_err, irq;
  logic [15:0] gpio_in, gpio_out;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  mmio_gpio_ctrl #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE(4), .BASE_ADDR(32'h0000_0400)) dut (
    .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .bus_err(bus_err),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    tick();
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = addr;
    exp_q.push_back(exp);
    tick();
    bus_valid = 1'b0;
    check("rvalid_at_plus1", 32'(bus_rvalid), 32'd1);
  endtask

  // Scoreboard: every read-data strobe pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus_rvalid) begin
      if (exp_q.size() == 0) check("spurious_rvalid", 32'(bus_rvalid), 32'd0);
      else check("rdata", bus_rdata, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; gpio_in = '0;
    repeat (3) tick();
    check("rst_gpio_out", 32'(gpio_out), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rvalid", 32'(bus_rvalid), 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    rst_n = 1'b1;
    rd(A_IN, 32'd0);

    // Output register operations
    wr(A_OUT, 32'h00F0); check("out_write", 32'(gpio_out), 32'h00F0);
    wr(A_SET, 32'h0003); check("out_set", 32'(gpio_out), 32'h00F3);
    wr(A_CLR, 32'h0010); check("out_clr", 32'(gpio_out), 32'h00E3);
    rd(A_OUT, 32'h0000_00E3);

    // Glitch of 3 cycles must be filtered
    wr(A_IEN, 32'h1);
    gpio_in = 16'h0001;
    repeat (3) tick();
    gpio_in = 16'h0000;
    repeat (10) tick();
    check("glitch_irq", 32'(irq), 32'd0);
    rd(A_IN, 32'd0);
    rd(A_STAT, 32'd0);

    // Stable rise: IN follows after exactly SYNC_STAGES+DEBOUNCE edges
    gpio_in = 16'h0001;
    repeat (4) tick();
    rd(A_IN, 32'd0);
    rd(A_IN, 32'd0);
    check("irq_not_yet", 32'(irq), 32'd0);
    rd(A_IN, 32'd1);
    check("irq_rise", 32'(irq), 32'd1);
    rd(A_STAT, 32'd1);
    wr(A_STAT, 32'h1);
    check("irq_lag_w1c", 32'(irq), 32'd1);
    tick();
    check("irq_cleared", 32'(irq), 32'd0);
    rd(A_STAT, 32'd0);

    // Falling-edge polarity; the POL write itself creates no event
    wr(A_POL, 32'h1);
    rd(A_STAT, 32'd0);
    gpio_in = 16'h0000;
    repeat (8) tick();
    rd(A_STAT, 32'd1);
    rd(A_IN, 32'd0);
    check("irq_fall", 32'(irq), 32'd1);
    wr(A_STAT, 32'h1);
    tick();
    check("irq_fall_cleared", 32'(irq), 32'd0);

    // W1C collides with a new rising event on bit 2
    wr(A_IEN, 32'h5);
    gpio_in = 16'h0004;
    repeat (5) tick();
    wr(A_STAT, 32'h4);
    rd(A_STAT, 32'h4);
    check("irq_collision", 32'(irq), 32'd1);

    // Decode: unmapped offset, out-of-window access, width masking
    rd(A_NONE, 32'd0);
    check("err_read", 32'(bus_err), 32'd1);
    tick();
    check("err_pulse_end", 32'(bus_err), 32'd0);
    wr(A_NONE, 32'hFFFF_FFFF);
    check("err_write", 32'(bus_err), 32'd1);
    check("unmapped_wr_no_effect", 32'(gpio_out), 32'h00E3);
    wr(32'h504, 32'h1234);
    check("miss_wr_out", 32'(gpio_out), 32'h00E3);
    check("miss_wr_err", 32'(bus_err), 32'd0);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 32'h500;
    tick();
    bus_valid = 1'b0;
    check("miss_rd_rvalid", 32'(bus_rvalid), 32'd0);
    check("miss_rd_err", 32'(bus_err), 32'd0);
    wr(A_OUT, 32'hFFFF_FFFF);
    check("out_masked", 32'(gpio_out), 32'h0000_FFFF);
    rd(A_OUT, 32'h0000_FFFF);
    wr(A_CLR, 32'hFF00);
    check("clr_high", 32'(gpio_out), 32'h0000_00FF);
    check("rdata_hold", bus_rdata, 32'h0000_FFFF);
    rd(A_SET, 32'd0);
    rd(A_CLR, 32'd0);
    rd(A_IEN, 32'h5);
    rd(A_POL, 32'h1);

    // Reset mid-stream with a read strobe in flight
    rd(A_OUT, 32'h0000_00FF);
    #2;
    rst_n = 1'b0;
    gpio_in = 16'h0001;
    #1;
    check("async_rst_gpio_out", 32'(gpio_out), 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    check("async_rst_rvalid", 32'(bus_rvalid), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    rd(A_IN, 32'd0);
    repeat (8) tick();
    rd(A_STAT, 32'd1);
    rd(A_IN, 32'd1);
    check("post_rst_irq", 32'(irq), 32'd0);
    rd(A_OUT, 32'd0);

    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
